// File: rtl/vsynth_nco_pkg.sv
// Shared types and default widths for the NCO voice array and its sample ROM.
package vsynth_nco_pkg;

  localparam int N_VOICES_DEF = 8;
  localparam int PROG_W_DEF   = 7;
  localparam int SAMPLE_W_DEF = 6;
  localparam int DATA_W_DEF   = 8;
  localparam int VOICE_W_DEF  = $clog2(N_VOICES_DEF);

  typedef struct packed {
    logic [PROG_W_DEF-1:0]   prog;
    logic [SAMPLE_W_DEF-1:0] sample;
  } rom_addr_t;

  typedef logic [VOICE_W_DEF-1:0] voice_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] rr_ptr
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               j;

  // Scan from the pointer upward (mod N); the first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr_q) + off) % N;
      if (en && !found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign rr_ptr = ptr_q;

endmodule

// File: rtl/sample_rom_arbiter.sv
// Round-robin sharing of the single-port sample ROM between NCO voices, responses tagged by voice.
// Optional per-voice one-entry cache enabled by defining SAMPLE_ARB_CACHE_EN.
module sample_rom_arbiter
  import vsynth_nco_pkg::*;
#(
  parameter int N_VOICES = N_VOICES_DEF,
  parameter int PROG_W   = PROG_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  localparam int VOICE_W = $clog2(N_VOICES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_VOICES-1:0]          req,
  input  logic [N_VOICES*PROG_W-1:0]   req_prog,
  input  logic [N_VOICES*SAMPLE_W-1:0] req_sample,
  output logic [N_VOICES-1:0]          gnt,
  output logic                         rom_re,
  output logic [PROG_W-1:0]            rom_addr_prog,
  output logic [SAMPLE_W-1:0]          rom_addr_sample,
  input  logic [DATA_W-1:0]            rom_data,
  output logic                         rsp_valid,
  output logic [VOICE_W-1:0]           rsp_voice,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         busy
);

  logic [VOICE_W-1:0] gnt_idx;
  logic [VOICE_W-1:0] rr_ptr;
  logic               any_gnt;
  logic               rsp_valid_q;
  logic [VOICE_W-1:0] rsp_voice_q;

  // Reset also masks the combinational grant so nothing is offered while held in reset.
  rr_arbiter #(.N(N_VOICES)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (en & ~rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .rr_ptr  (rr_ptr)
  );

  assign any_gnt = |gnt;

  always_comb begin
    rom_addr_prog   = '0;
    rom_addr_sample = '0;
    if (any_gnt) begin
      rom_addr_prog   = req_prog[int'(gnt_idx)*PROG_W +: PROG_W];
      rom_addr_sample = req_sample[int'(gnt_idx)*SAMPLE_W +: SAMPLE_W];
    end
  end

  // ---- grant stage -> response stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_voice_q <= '0;
    end else begin
      rsp_valid_q <= any_gnt;
      if (any_gnt) rsp_voice_q <= gnt_idx;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_voice = rsp_voice_q;
  assign busy      = rsp_valid_q;

`ifdef SAMPLE_ARB_CACHE_EN
  logic [N_VOICES-1:0] cvld_q;
  logic [PROG_W-1:0]   cprog_q [N_VOICES];
  logic [SAMPLE_W-1:0] csamp_q [N_VOICES];
  logic [DATA_W-1:0]   cdata_q [N_VOICES];
  logic [PROG_W-1:0]   rsp_prog_q;
  logic [SAMPLE_W-1:0] rsp_samp_q;
  logic                hit, hit_q, fill;

  assign hit = any_gnt && cvld_q[gnt_idx]
               && (cprog_q[gnt_idx] == rom_addr_prog)
               && (csamp_q[gnt_idx] == rom_addr_sample);
  assign rom_re = any_gnt & ~hit;
  // Only genuine ROM returns refill the entry; hits already match it.
  assign fill = rsp_valid_q & ~hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      cvld_q <= '0;
    end else begin
      hit_q <= hit;
      if (fill) cvld_q[rsp_voice_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rsp_prog_q <= rom_addr_prog;
    rsp_samp_q <= rom_addr_sample;
    if (fill) begin
      cprog_q[rsp_voice_q] <= rsp_prog_q;
      csamp_q[rsp_voice_q] <= rsp_samp_q;
      cdata_q[rsp_voice_q] <= rom_data;
    end
  end

  assign rsp_data = hit_q ? cdata_q[rsp_voice_q] : rom_data;
`else
  assign rom_re   = any_gnt;
  assign rsp_data = rom_data;
`endif

endmodule

// File: tb/tb_sample_rom_arbiter.sv
// Directed bench for sample_rom_arbiter with a 1-cycle-latency ROM model.
module tb_sample_rom_arbiter;

  localparam int NV = 8;
  localparam int PW = 7;
  localparam int SW = 6;
  localparam int DW = 8;
  localparam int VW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NV-1:0]     req;
  logic [NV*PW-1:0]  req_prog;
  logic [NV*SW-1:0]  req_sample;
  logic [NV-1:0]     gnt;
  logic              rom_re;
  logic [PW-1:0]     rom_addr_prog;
  logic [SW-1:0]     rom_addr_sample;
  logic [DW-1:0]     rom_data = '0;
  logic              rsp_valid;
  logic [VW-1:0]     rsp_voice;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  logic [PW-1:0] bp [NV];
  logic [SW-1:0] bs [NV];
  int n_chk = 0;
  int n_pass = 0;
  int n_rsp;

  always #5 clk = ~clk;

  sample_rom_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .req             (req),
    .req_prog        (req_prog),
    .req_sample      (req_sample),
    .gnt             (gnt),
    .rom_re          (rom_re),
    .rom_addr_prog   (rom_addr_prog),
    .rom_addr_sample (rom_addr_sample),
    .rom_data        (rom_data),
    .rsp_valid       (rsp_valid),
    .rsp_voice       (rsp_voice),
    .rsp_data        (rsp_data),
    .busy            (busy)
  );

  function automatic logic [DW-1:0] romf(input logic [PW-1:0] p, input logic [SW-1:0] s);
    return {p[3:0], 4'h0} ^ {2'b00, s} ^ 8'h5A;
  endfunction

  // ROM contents are a fixed function of the address; output is 0 when not read.
  always @(posedge clk) begin
    rom_data <= rom_re ? romf(rom_addr_prog, rom_addr_sample) : '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_addr(input int v, input logic [PW-1:0] p, input logic [SW-1:0] s);
    bp[v] = p;
    bs[v] = s;
    req_prog[v*PW +: PW]   = p;
    req_sample[v*SW +: SW] = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = '1;
    req_prog = '0;
    req_sample = '0;
    for (int v = 0; v < NV; v++) set_addr(v, PW'(v + 16), SW'(v * 5));

    // Reset holds everything idle even with all voices requesting
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rom_re", 32'(rom_re), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_voice", 32'(rsp_voice), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    chk("first_gnt", 32'(gnt), 32'h01);
    chk("first_rom_re", 32'(rom_re), 1);
    chk("first_addr_prog", 32'(rom_addr_prog), 32'h10);
    step();
    req = '0;
    #1;
    chk("first_rsp_valid", 32'(rsp_valid), 1);
    chk("first_rsp_voice", 32'(rsp_voice), 0);
    chk("first_rsp_data", 32'(rsp_data), 32'(romf(bp[0], bs[0])));
    chk("first_busy", 32'(busy), 1);

    // Single voice 2
    set_addr(2, 7'h12, 6'h3F);
    req = 8'h04;
    #1;
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_prog", 32'(rom_addr_prog), 32'h12);
    chk("single_sample", 32'(rom_addr_sample), 32'h3F);
    chk("single_rom_re", 32'(rom_re), 1);
    step();
    req = '0;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_voice", 32'(rsp_voice), 2);
    chk("single_rsp_data", 32'(rsp_data), 32'(romf(7'h12, 6'h3F)));
    step();
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_addr_prog", 32'(rom_addr_prog), 0);

    // All voices for 16 cycles from a fresh pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    n_rsp = 0;
    for (int c = 0; c < 16; c++) begin
      req = '1;
      #1;
      chk($sformatf("all_gnt%0d", c), 32'(gnt), 32'(1) << (c % 8));
      if (c > 0) begin
        chk($sformatf("all_rsp_voice%0d", c), 32'(rsp_voice), 32'((c - 1) % 8));
        chk($sformatf("all_rsp_data%0d", c), 32'(rsp_data),
            32'(romf(bp[(c - 1) % 8], bs[(c - 1) % 8])));
      end
      if (rsp_valid) n_rsp++;
      step();
    end
    req = '0;
    #1;
    chk("all_last_voice", 32'(rsp_voice), 7);
    if (rsp_valid) n_rsp++;
    step();
    if (rsp_valid) n_rsp++;
    chk("all_rsp_count", 32'(n_rsp), 16);

    // Voices 3 and 5 with the pointer at 4
    req = 8'h08;
    #1;
    chk("pre_gnt3", 32'(gnt), 32'h08);
    step();
    req = 8'h28;
    #1;
    chk("ptr4_gnt5", 32'(gnt), 32'h20);
    step();
    #1;
    chk("ptr4_gnt3", 32'(gnt), 32'h08);
    chk("ptr4_rsp5", 32'(rsp_voice), 5);
    step();
    #1;
    chk("ptr4_gnt5_again", 32'(gnt), 32'h20);
    chk("ptr4_rsp3", 32'(rsp_voice), 3);
    step();
    req = '0;

    // en dropped after a grant; pointer is at 6 here
    req = 8'h01;
    #1;
    chk("en_gnt0", 32'(gnt), 32'h01);
    step();
    en  = 1'b0;
    req = '1;
    #1;
    chk("en_off_gnt", 32'(gnt), 0);
    chk("en_off_rom_re", 32'(rom_re), 0);
    chk("en_off_rsp_valid", 32'(rsp_valid), 1);
    chk("en_off_rsp_voice", 32'(rsp_voice), 0);
    chk("en_off_rsp_data", 32'(rsp_data), 32'(romf(bp[0], bs[0])));
    step();
    chk("en_off_rsp_gone", 32'(rsp_valid), 0);
    chk("en_off_gnt2", 32'(gnt), 0);
    step();
    chk("en_off_gnt3", 32'(gnt), 0);
    en = 1'b1;
    #1;
    chk("en_on_gnt", 32'(gnt), 32'h02);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_gnt", 32'(gnt), 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ptr0", 32'(gnt), 32'h01);
    req = '0;
    step();

    // Repeated address from voice 1
    set_addr(1, 7'h05, 6'h07);
    req = 8'h02;
    #1;
    chk("cache_miss_re", 32'(rom_re), 1);
    step();
    req = '0;
    #1;
    chk("cache_first_data", 32'(rsp_data), 32'(romf(7'h05, 6'h07)));
    step();
    req = 8'h02;
    #1;
    chk("cache_again_gnt", 32'(gnt), 32'h02);
`ifdef SAMPLE_ARB_CACHE_EN
    chk("cache_hit_re", 32'(rom_re), 0);
`else
    chk("cache_hit_re", 32'(rom_re), 1);
`endif
    step();
    req = '0;
    #1;
    chk("cache_hit_valid", 32'(rsp_valid), 1);
    chk("cache_hit_voice", 32'(rsp_voice), 1);
    chk("cache_hit_data", 32'(rsp_data), 32'(romf(7'h05, 6'h07)));
    step();
    set_addr(1, 7'h05, 6'h08);
    req = 8'h02;
    #1;
    chk("cache_newaddr_re", 32'(rom_re), 1);
    step();
    req = '0;
    #1;
    chk("cache_newaddr_data", 32'(rsp_data), 32'(romf(7'h05, 6'h08)));
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
